// File: rtl/silife_pkg.sv
`default_nettype none
// ============================================================================
// silife_pkg : shared types and constants for the grid write arbiter
// Rev 1.0
// ============================================================================
package silife_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_COOL  = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_LOADER = 1'b0,
        SRC_CPU    = 1'b1
    } src_t;

    localparam int STATS_W = 16;
    localparam logic [STATS_W-1:0] STATS_ONE = {{(STATS_W-1){1'b0}}, 1'b1};
    localparam logic [STATS_W-1:0] STATS_MAX = {STATS_W{1'b1}};

    function automatic src_t other_src(input src_t s);
        return (s == SRC_LOADER) ? SRC_CPU : SRC_LOADER;
    endfunction

endpackage
`default_nettype wire

// File: rtl/silife_write_skid.sv
`default_nettype none
// ============================================================================
// silife_write_skid : 1-entry loader write buffer with sticky overflow flag
// Rev 1.0
// ============================================================================
module silife_write_skid #(
    parameter int WIDTH    = 32,
    parameter int ROW_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ld_valid,
    input  logic [ROW_BITS-1:0] ld_row,
    input  logic [WIDTH-1:0]    ld_set,
    input  logic [WIDTH-1:0]    ld_clear,
    input  logic                take,
    input  logic                clear_overflow,
    output logic                valid,
    output logic [ROW_BITS-1:0] row,
    output logic [WIDTH-1:0]    set_mask,
    output logic [WIDTH-1:0]    clear_mask,
    output logic                overflow
);

    logic accept;
    logic drop;

    // A slot being drained this cycle can be refilled in the same cycle.
    assign accept = ld_valid & (~valid | take);
    assign drop   = ld_valid & valid & ~take;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid      <= 1'b0;
            row        <= '0;
            set_mask   <= '0;
            clear_mask <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept) begin
                valid      <= 1'b1;
                row        <= ld_row;
                set_mask   <= ld_set;
                clear_mask <= ld_clear;
            end else if (take) begin
                valid      <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/silife_grid_write_arbiter.sv
`default_nettype none
// ============================================================================
// silife_grid_write_arbiter : shares the grid row-write port between the SPI
// loader and the CPU, issuing writes only between evolution steps.
// Optional per-source write counters: SILIFE_ARB_STATS_EN
// Rev 1.0
// ============================================================================
module silife_grid_write_arbiter
    import silife_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int HEIGHT   = 32,
    localparam int ROW_BITS = $clog2(HEIGHT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_ld_valid,
    input  logic [ROW_BITS-1:0] i_ld_row,
    input  logic [WIDTH-1:0]    i_ld_set,
    input  logic [WIDTH-1:0]    i_ld_clear,
    input  logic                i_cpu_req,
    input  logic [ROW_BITS-1:0] i_cpu_row,
    input  logic [WIDTH-1:0]    i_cpu_set,
    input  logic [WIDTH-1:0]    i_cpu_clear,
    output logic                o_cpu_ack,
    input  logic                i_evolve_busy,
    output logic                o_evolve_hold,
    output logic                o_write,
    output logic [ROW_BITS-1:0] o_row_select,
    output logic [WIDTH-1:0]    o_set_cells,
    output logic [WIDTH-1:0]    o_clear_cells,
    output logic                o_ld_overflow,
    input  logic                i_clear_overflow,
    output logic [STATS_W-1:0]  o_ld_count,
    output logic [STATS_W-1:0]  o_cpu_count
);

    arb_state_t          state;
    arb_state_t          state_next;
    src_t                rr_ptr;
    src_t                issue_src;
    logic                cpu_req_q;
    logic                busy_q;

    logic                buf_valid;
    logic [ROW_BITS-1:0] buf_row;
    logic [WIDTH-1:0]    buf_set;
    logic [WIDTH-1:0]    buf_clear;

    logic                arb_open;
    logic                ld_cand;
    logic                cpu_cand;
    logic                grant_ld;
    logic                grant_cpu;

    logic                write_q;
    logic                ack_q;
    logic [ROW_BITS-1:0] row_q;
    logic [WIDTH-1:0]    set_q;
    logic [WIDTH-1:0]    clear_q;

    silife_write_skid #(
        .WIDTH    (WIDTH),
        .ROW_BITS (ROW_BITS)
    ) u_skid (
        .clk            (clk),
        .reset          (reset),
        .ld_valid       (i_ld_valid),
        .ld_row         (i_ld_row),
        .ld_set         (i_ld_set),
        .ld_clear       (i_ld_clear),
        .take           (grant_ld),
        .clear_overflow (i_clear_overflow),
        .valid          (buf_valid),
        .row            (buf_row),
        .set_mask       (buf_set),
        .clear_mask     (buf_clear),
        .overflow       (o_ld_overflow)
    );

    // The CPU request and busy are seen one cycle late so a CPU request and a
    // loader pulse in the same cycle contend together with the buffered write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cpu_req_q <= i_cpu_req;
            busy_q    <= i_evolve_busy;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= SRC_LOADER;
            issue_src <= SRC_LOADER;
        end else begin
            state <= state_next;
            if (grant_ld) begin
                rr_ptr    <= other_src(SRC_LOADER);
                issue_src <= SRC_LOADER;
            end else if (grant_cpu) begin
                rr_ptr    <= other_src(SRC_CPU);
                issue_src <= SRC_CPU;
            end
        end
    end

    always_comb begin
        state_next = state;
        arb_open   = 1'b0;
        ld_cand    = 1'b0;
        cpu_cand   = 1'b0;
        grant_ld   = 1'b0;
        grant_cpu  = 1'b0;

        // Either edge of busy blocks a grant, so a rising busy is never raced.
        arb_open = ((state == ST_IDLE) || (state == ST_COOL)) && !i_evolve_busy && !busy_q;
        ld_cand  = arb_open && buf_valid;
        // COOL masks the request the CPU is still holding after its ack.
        cpu_cand = arb_open && (state == ST_IDLE) && cpu_req_q;

        grant_ld  = ld_cand && (!cpu_cand || (rr_ptr == SRC_LOADER));
        grant_cpu = cpu_cand && (!ld_cand || (rr_ptr == SRC_CPU));

        case (state)
            ST_IDLE: begin
                if (grant_ld || grant_cpu) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = (issue_src == SRC_CPU) ? ST_COOL : ST_IDLE;
            end
            ST_COOL: begin
                state_next = grant_ld ? ST_ISSUE : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_q <= 1'b0;
            ack_q   <= 1'b0;
            row_q   <= '0;
            set_q   <= '0;
            clear_q <= '0;
        end else begin
            write_q <= grant_ld | grant_cpu;
            ack_q   <= grant_cpu;
            if (grant_ld) begin
                row_q   <= buf_row;
                set_q   <= buf_set;
                clear_q <= buf_clear & ~buf_set;
            end else if (grant_cpu) begin
                row_q   <= i_cpu_row;
                set_q   <= i_cpu_set;
                clear_q <= i_cpu_clear & ~i_cpu_set;
            end else begin
                row_q   <= '0;
                set_q   <= '0;
                clear_q <= '0;
            end
        end
    end

    assign o_write       = write_q;
    assign o_cpu_ack     = ack_q;
    assign o_row_select  = row_q;
    assign o_set_cells   = set_q;
    assign o_clear_cells = clear_q;
    assign o_evolve_hold = reset & (buf_valid | i_cpu_req | (state != ST_IDLE));

`ifdef SILIFE_ARB_STATS_EN
    logic [STATS_W-1:0] ld_count;
    logic [STATS_W-1:0] cpu_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_count  <= '0;
            cpu_count <= '0;
        end else if (state == ST_ISSUE) begin
            if ((issue_src == SRC_LOADER) && (ld_count != STATS_MAX)) begin
                ld_count <= ld_count + STATS_ONE;
            end
            if ((issue_src == SRC_CPU) && (cpu_count != STATS_MAX)) begin
                cpu_count <= cpu_count + STATS_ONE;
            end
        end
    end

    assign o_ld_count  = ld_count;
    assign o_cpu_count = cpu_count;
`else
    assign o_ld_count  = '0;
    assign o_cpu_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_silife_grid_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_silife_grid_write_arbiter : directed table-driven bench for the arbiter
// Rev 1.0
// ============================================================================
module tb_silife_grid_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic [4:0]  ld_row;
    logic [31:0] ld_set;
    logic [31:0] ld_clear;
    logic        cpu_req;
    logic [4:0]  cpu_row;
    logic [31:0] cpu_set;
    logic [31:0] cpu_clear;
    logic        cpu_ack;
    logic        evolve_busy;
    logic        evolve_hold;
    logic        write;
    logic [4:0]  row_select;
    logic [31:0] set_cells;
    logic [31:0] clear_cells;
    logic        ld_overflow;
    logic        clear_overflow;
    logic [15:0] ld_count;
    logic [15:0] cpu_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    silife_grid_write_arbiter #(
        .WIDTH  (32),
        .HEIGHT (32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .i_ld_valid       (ld_valid),
        .i_ld_row         (ld_row),
        .i_ld_set         (ld_set),
        .i_ld_clear       (ld_clear),
        .i_cpu_req        (cpu_req),
        .i_cpu_row        (cpu_row),
        .i_cpu_set        (cpu_set),
        .i_cpu_clear      (cpu_clear),
        .o_cpu_ack        (cpu_ack),
        .i_evolve_busy    (evolve_busy),
        .o_evolve_hold    (evolve_hold),
        .o_write          (write),
        .o_row_select     (row_select),
        .o_set_cells      (set_cells),
        .o_clear_cells    (clear_cells),
        .o_ld_overflow    (ld_overflow),
        .i_clear_overflow (clear_overflow),
        .o_ld_count       (ld_count),
        .o_cpu_count      (cpu_count)
    );

    typedef struct {
        logic        lv;
        logic [4:0]  lr;
        logic [31:0] ls;
        logic [31:0] lc;
        logic        rq;
        logic [4:0]  cr;
        logic [31:0] cs;
        logic [31:0] cc;
        logic        ew;
        logic        ea;
        logic [4:0]  er;
        logic [31:0] es;
        logic [31:0] ec;
        logic        eh;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(logic lv, logic [4:0] lr, logic [31:0] ls, logic [31:0] lc,
                                logic rq, logic [4:0] cr, logic [31:0] cs, logic [31:0] cc,
                                logic ew, logic ea, logic [4:0] er, logic [31:0] es,
                                logic [31:0] ec, logic eh);
        vec_t v;
        v.lv = lv; v.lr = lr; v.ls = ls; v.lc = lc;
        v.rq = rq; v.cr = cr; v.cs = cs; v.cc = cc;
        v.ew = ew; v.ea = ea; v.er = er; v.es = es; v.ec = ec; v.eh = eh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_valid = 0; ld_row = 0; ld_set = 0; ld_clear = 0;
        cpu_req = 0; cpu_row = 0; cpu_set = 0; cpu_clear = 0;
        evolve_busy = 0; clear_overflow = 0;
    endtask

    initial begin
        // Cycle-by-cycle: loader only, CPU only, two contention rounds.
        vecs[0]  = mk(1, 5, 32'h1, 32'h0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0,          0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        vecs[2]  = mk(0, 0, 0, 0,          0, 0, 0, 0,  1, 0, 5, 32'h1, 0, 1);
        vecs[3]  = mk(0, 0, 0, 0,          0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0,  1, 3, 32'hF0, 32'hFF,  0, 0, 0, 0, 0, 1);
        vecs[5]  = mk(0, 0, 0, 0,  1, 3, 32'hF0, 32'hFF,  0, 0, 0, 0, 0, 1);
        vecs[6]  = mk(0, 0, 0, 0,  1, 3, 32'hF0, 32'hFF,  1, 1, 3, 32'hF0, 32'h0F, 1);
        vecs[7]  = mk(0, 0, 0, 0,          0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        vecs[8]  = mk(0, 0, 0, 0,          0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0,          0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[10] = mk(1, 7, 32'h00FF0000, 32'h0FFFFFFF,  1, 9, 32'hA, 32'hF,  0, 0, 0, 0, 0, 1);
        vecs[11] = mk(0, 0, 0, 0,  1, 9, 32'hA, 32'hF,  0, 0, 0, 0, 0, 1);
        vecs[12] = mk(0, 0, 0, 0,  1, 9, 32'hA, 32'hF,  1, 0, 7, 32'h00FF0000, 32'h0F00FFFF, 1);
        vecs[13] = mk(0, 0, 0, 0,  1, 9, 32'hA, 32'hF,  0, 0, 0, 0, 0, 1);
        vecs[14] = mk(0, 0, 0, 0,  1, 9, 32'hA, 32'hF,  1, 1, 9, 32'hA, 32'h5, 1);
        vecs[15] = mk(0, 0, 0, 0,          0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        vecs[16] = mk(0, 0, 0, 0,          0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[17] = mk(1, 1, 32'h1, 32'h0,  1, 2, 32'h2, 32'h0,  0, 0, 0, 0, 0, 1);
        vecs[18] = mk(0, 0, 0, 0,  1, 2, 32'h2, 32'h0,  0, 0, 0, 0, 0, 1);
        vecs[19] = mk(0, 0, 0, 0,  1, 2, 32'h2, 32'h0,  1, 0, 1, 32'h1, 32'h0, 1);
        vecs[20] = mk(0, 0, 0, 0,  1, 2, 32'h2, 32'h0,  0, 0, 0, 0, 0, 1);
        vecs[21] = mk(0, 0, 0, 0,  1, 2, 32'h2, 32'h0,  1, 1, 2, 32'h2, 32'h0, 1);
        vecs[22] = mk(0, 0, 0, 0,          0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        vecs[23] = mk(0, 0, 0, 0,          0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        idle_inputs();
        reset = 1'b0;
        repeat (3) tick();
        chk("reset_write",    32'(write), 32'h0);
        chk("reset_ack",      32'(cpu_ack), 32'h0);
        chk("reset_hold",     32'(evolve_hold), 32'h0);
        chk("reset_overflow", 32'(ld_overflow), 32'h0);
        chk("reset_row",      32'(row_select), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 24; i++) begin
            ld_valid = vecs[i].lv; ld_row = vecs[i].lr; ld_set = vecs[i].ls; ld_clear = vecs[i].lc;
            cpu_req = vecs[i].rq; cpu_row = vecs[i].cr; cpu_set = vecs[i].cs; cpu_clear = vecs[i].cc;
            #1;
            chk($sformatf("vec%0d_write", i), 32'(write), 32'(vecs[i].ew));
            chk($sformatf("vec%0d_ack", i),   32'(cpu_ack), 32'(vecs[i].ea));
            chk($sformatf("vec%0d_row", i),   32'(row_select), 32'(vecs[i].er));
            chk($sformatf("vec%0d_set", i),   set_cells, vecs[i].es);
            chk($sformatf("vec%0d_clear", i), clear_cells, vecs[i].ec);
            chk($sformatf("vec%0d_hold", i),  32'(evolve_hold), 32'(vecs[i].eh));
            tick();
        end
        idle_inputs();
        tick();

        // Busy gating: CPU request waits out 10 busy cycles.
        evolve_busy = 1; cpu_req = 1; cpu_row = 10; cpu_set = 32'h0F0F; cpu_clear = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("busy_no_write", 32'(write), 32'h0);
            chk("busy_hold", 32'(evolve_hold), 32'h1);
            tick();
        end
        evolve_busy = 0;
        #1; chk("busy_fall_c0", 32'(write), 32'h0);
        tick(); chk("busy_fall_c1", 32'(write), 32'h0);
        tick();
        chk("busy_write", 32'(write), 32'h1);
        chk("busy_ack", 32'(cpu_ack), 32'h1);
        chk("busy_row", 32'(row_select), 32'd10);
        chk("busy_set", set_cells, 32'h0F0F);
        tick(); cpu_req = 0;
        #1; chk("busy_after", 32'(write), 32'h0);
        tick(); tick();

        // Overflow: second pulse while the buffer is full and blocked is dropped.
        evolve_busy = 1;
        ld_valid = 1; ld_row = 4; ld_set = 32'h11; ld_clear = 32'h22;
        tick(); ld_valid = 0;
        #1; chk("ovf_first_kept", 32'(ld_overflow), 32'h0);
        tick(); tick();
        ld_valid = 1; ld_row = 6; ld_set = 32'h33; ld_clear = 0;
        tick(); ld_valid = 0;
        #1; chk("ovf_set", 32'(ld_overflow), 32'h1);
        chk("ovf_hold", 32'(evolve_hold), 32'h1);
        tick(); evolve_busy = 0;
        #1; chk("ovf_wait0", 32'(write), 32'h0);
        tick(); chk("ovf_wait1", 32'(write), 32'h0);
        tick();
        chk("ovf_write", 32'(write), 32'h1);
        chk("ovf_row", 32'(row_select), 32'd4);
        chk("ovf_set_cells", set_cells, 32'h11);
        chk("ovf_clear_cells", clear_cells, 32'h22);
        tick(); chk("ovf_single0", 32'(write), 32'h0);
        tick(); chk("ovf_single1", 32'(write), 32'h0);
        chk("ovf_sticky", 32'(ld_overflow), 32'h1);
        clear_overflow = 1;
        tick(); clear_overflow = 0;
        #1; chk("ovf_cleared", 32'(ld_overflow), 32'h0);

        // Overflow event and clear request in the same cycle: set wins.
        evolve_busy = 1;
        ld_valid = 1; ld_row = 2; ld_set = 32'h5; ld_clear = 0;
        tick();
        ld_row = 3; ld_set = 32'h6; clear_overflow = 1;
        tick();
        ld_valid = 0; clear_overflow = 0; evolve_busy = 0;
        #1; chk("ovf_set_wins", 32'(ld_overflow), 32'h1);
        tick(); tick();
        chk("ovf2_write", 32'(write), 32'h1);
        chk("ovf2_row", 32'(row_select), 32'd2);
        clear_overflow = 1;
        tick(); clear_overflow = 0;
        tick();

        // Async reset in the middle of a CPU ISSUE cycle.
        cpu_req = 1; cpu_row = 8; cpu_set = 32'hFF; cpu_clear = 0;
        tick(); tick();
        chk("rst_pre_write", 32'(write), 32'h1);
        #2 reset = 0;
        #1;
        chk("rst_write", 32'(write), 32'h0);
        chk("rst_ack", 32'(cpu_ack), 32'h0);
        chk("rst_row", 32'(row_select), 32'h0);
        chk("rst_set", set_cells, 32'h0);
        chk("rst_clear", clear_cells, 32'h0);
        chk("rst_hold", 32'(evolve_hold), 32'h0);
        chk("rst_overflow", 32'(ld_overflow), 32'h0);
        cpu_req = 0;
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_ack", 32'(cpu_ack), 32'h0);
            chk("rst_no_write", 32'(write), 32'h0);
        end
        ld_valid = 1; ld_row = 12; ld_set = 32'h80000000; ld_clear = 32'h1;
        tick(); ld_valid = 0;
        tick();
        chk("post_rst_write", 32'(write), 32'h1);
        chk("post_rst_row", 32'(row_select), 32'd12);
        chk("post_rst_set", set_cells, 32'h80000000);
        chk("post_rst_clear", clear_cells, 32'h1);
        tick();
`ifdef SILIFE_ARB_STATS_EN
        chk("stats_ld", 32'(ld_count), 32'd1);
        chk("stats_cpu", 32'(cpu_count), 32'd0);
`else
        chk("stats_ld_tied", 32'(ld_count), 32'd0);
        chk("stats_cpu_tied", 32'(cpu_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
